// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered multi-cycle ALU.
//   - cop encodings (OP_*), 4 bits wide
//   - FSM state encoding (state_t: S_IDLE, S_BUSY, S_DONE)
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MOV = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, reset     clock / asynchronous active-high reset (control only)
//   start          load operands and perform the first iteration
//   a, b           multiplicand / multiplier, sampled on start
//   busy           iterations in progress
//   done           the final iteration is being performed this cycle;
//                  product carries the complete result while done is high
//   count          iterations already registered (1 after start)
//   product        2*WIDTH result of the iteration under way
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(WIDTH):0]  count,
  output logic [2*WIDTH-1:0]      product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // acc holds {partial sum, remaining multiplier bits}; every step adds the
  // multiplicand when the current multiplier LSB is set and shifts right.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] acc,
    input logic [WIDTH-1:0]   mcand
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  logic [2*WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0]   mcand_p0;

  // The first iteration happens on the start edge, so the last one lands on
  // the edge where count == WIDTH-1 and is handed out combinationally.
  assign product = mul_step(acc_p0, mcand_p0);
  assign done    = busy && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CNT_W'(1);
    end else if (busy) begin
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // ---- stage p0: iteration registers ----
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0   <= mul_step({{WIDTH{1'b0}}, b}, a);
      mcand_p0 <= a;
    end else if (busy) begin
      acc_p0   <= product;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered ALU with valid/ready handshake, flag register and a
// sequential multiplier.
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   in_valid, in_ready    request handshake (in_ready only in IDLE)
//   cop, reg_A, reg_B     operation and operands, captured on acceptance
//   out_valid             one-cycle pulse: result / flags / illegal valid
//   out_wr                result is to be written back
//   result                registered result
//   OVF, Z, N             persistent flag register
//   illegal               accepted cop was not a defined operation
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cop,
  input  logic [WIDTH-1:0] reg_A,
  input  logic [WIDTH-1:0] reg_B,
  output logic             out_valid,
  output logic             out_wr,
  output logic [WIDTH-1:0] result,
  output logic             OVF,
  output logic             Z,
  output logic             N,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] TO_DONE_AT = CNT_W'(WIDTH - 2);

  // Left shift returning {ovf, value}; ovf flags any 1 bit pushed out.
  function automatic logic [WIDTH:0] shl_ovf(
    input logic [WIDTH-1:0] a,
    input logic [CNT_W-1:0] amt
  );
    logic [2*WIDTH-1:0] wide;
    if (amt >= WIDTH_C) return {|a, {WIDTH{1'b0}}};
    wide = {{WIDTH{1'b0}}, a} << amt;
    return {|wide[2*WIDTH-1:WIDTH], wide[WIDTH-1:0]};
  endfunction

  state_t state;

  logic                 accept;
  logic [CNT_W-1:0]     amt_p0;
  logic [WIDTH:0]       sum_p0, dif_p0, shl_p0;
  logic [WIDTH-1:0]     val_p0;
  logic                 ovf_p0, wr_p0, upd_p0, bad_p0;

  logic                 mul_start, mul_busy, mul_done;
  logic [CNT_W-1:0]     mul_count;
  logic [2*WIDTH-1:0]   mul_prod;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (cop == OP_MUL);

  // ---- stage p0: single-cycle datapath on the request operands ----
  assign amt_p0 = reg_B[CNT_W-1:0];
  assign sum_p0 = {1'b0, reg_A} + {1'b0, reg_B};
  // Bit WIDTH of the difference is the unsigned borrow.
  assign dif_p0 = {1'b0, reg_A} - {1'b0, reg_B};
  assign shl_p0 = shl_ovf(reg_A, amt_p0);

  always_comb begin
    val_p0 = '0;
    ovf_p0 = 1'b0;
    wr_p0  = 1'b0;
    upd_p0 = 1'b1;
    bad_p0 = 1'b0;
    case (cop)
      OP_NOP: upd_p0 = 1'b0;
      OP_ADD: begin val_p0 = sum_p0[WIDTH-1:0]; ovf_p0 = sum_p0[WIDTH]; wr_p0 = 1'b1; end
      OP_SUB: begin val_p0 = dif_p0[WIDTH-1:0]; ovf_p0 = dif_p0[WIDTH]; wr_p0 = 1'b1; end
      OP_MOV: begin val_p0 = reg_B;             wr_p0  = 1'b1; end
      OP_CMP: begin val_p0 = dif_p0[WIDTH-1:0]; ovf_p0 = dif_p0[WIDTH]; end
      OP_AND: begin val_p0 = reg_A & reg_B;     wr_p0  = 1'b1; end
      OP_OR:  begin val_p0 = reg_A | reg_B;     wr_p0  = 1'b1; end
      OP_XOR: begin val_p0 = reg_A ^ reg_B;     wr_p0  = 1'b1; end
      OP_SHL: begin val_p0 = shl_p0[WIDTH-1:0]; ovf_p0 = shl_p0[WIDTH]; wr_p0 = 1'b1; end
      OP_SHR: begin val_p0 = reg_A >> amt_p0;   wr_p0  = 1'b1; end
      // MUL results come from the sequencer, not from this path.
      OP_MUL: upd_p0 = 1'b0;
      default: begin upd_p0 = 1'b0; bad_p0 = 1'b1; end
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (reg_A),
    .b       (reg_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .count   (mul_count),
    .product (mul_prod)
  );

  // ---- stage p1: FSM, output and flag registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
      OVF       <= 1'b0;
      Z         <= 1'b0;
      N         <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cop == OP_MUL) begin
              state <= S_BUSY;
            end else begin
              out_valid <= 1'b1;
              out_wr    <= wr_p0;
              illegal   <= bad_p0;
              if (wr_p0) result <= val_p0;
              if (upd_p0) begin
                OVF <= ovf_p0;
                Z   <= ~|val_p0;
                N   <= val_p0[WIDTH-1];
              end
            end
          end
        end
        S_BUSY: begin
          // DONE coincides with the multiplier's final iteration.
          if (!mul_busy)                    state <= S_IDLE;
          else if (mul_count == TO_DONE_AT) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          if (mul_done) begin
            out_valid <= 1'b1;
            out_wr    <= 1'b1;
            result    <= mul_prod[WIDTH-1:0];
            OVF       <= |mul_prod[2*WIDTH-1:WIDTH];
            Z         <= ~|mul_prod[WIDTH-1:0];
            N         <= mul_prod[WIDTH-1];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (WIDTH=16) with hand-computed
// expected values.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cop;
  logic [15:0] reg_A;
  logic [15:0] reg_B;
  logic        out_valid;
  logic        out_wr;
  logic [15:0] result;
  logic        OVF;
  logic        Z;
  logic        N;
  logic        illegal;

  int n_chk  = 0;
  int n_pass = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cop       (cop),
    .reg_A     (reg_A),
    .reg_B     (reg_B),
    .out_valid (out_valid),
    .out_wr    (out_wr),
    .result    (result),
    .OVF       (OVF),
    .Z         (Z),
    .N         (N),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // flags argument is {OVF, Z, N}
  task automatic check_out(input string tag, input logic wr, input logic [15:0] res,
                           input logic [2:0] flags);
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " out_wr"}, out_wr, wr);
    check({tag, " result"}, result, res);
    check({tag, " flags"}, {OVF, Z, N}, flags);
    check({tag, " illegal"}, illegal, 1'b0);
  endtask

  // Presents one request for a single edge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    cop      = c;
    reg_A    = a;
    reg_B    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen (bounded) and in_ready-low samples.
  task automatic wait_valid(output int edges, output int low);
    edges = 0;
    low   = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      if (in_ready === 1'b0) low++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int edges;
    int low;
    int pulses;

    reset    = 1'b1;
    in_valid = 1'b0;
    cop      = OP_NOP;
    reg_A    = '0;
    reg_B    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1'b0);
    check("rst result", result, 16'h0000);
    check("rst out_valid", out_valid, 1'b0);
    check("rst ctl/flags", {OVF, Z, N, illegal, out_wr}, 5'b00000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release in_ready", in_ready, 1'b1);

    issue(OP_ADD, 16'h0000, 16'h0001);
    check_out("add 0+1", 1'b1, 16'h0001, 3'b000);
    issue(OP_ADD, 16'hFFFF, 16'h0001);
    check_out("add carry", 1'b1, 16'h0000, 3'b110);
    issue(OP_SUB, 16'h0000, 16'h0001);
    check_out("sub borrow", 1'b1, 16'hFFFF, 3'b101);
    issue(OP_MOV, 16'h0000, 16'h1234);
    check_out("mov", 1'b1, 16'h1234, 3'b000);
    issue(OP_CMP, 16'h0001, 16'h0001);
    check_out("cmp eq", 1'b0, 16'h1234, 3'b010);
    @(posedge clk);
    #1;
    check("pulse width", out_valid, 1'b0);
    issue(OP_NOP, 16'hFFFF, 16'hFFFF);
    check_out("nop", 1'b0, 16'h1234, 3'b010);

    issue(OP_AND, 16'hF0F0, 16'hFF00);
    check_out("and", 1'b1, 16'hF000, 3'b001);
    issue(OP_OR, 16'h00F0, 16'h0F00);
    check_out("or", 1'b1, 16'h0FF0, 3'b000);
    issue(OP_XOR, 16'hAAAA, 16'hAAAA);
    check_out("xor", 1'b1, 16'h0000, 3'b010);
    issue(OP_SHL, 16'h8001, 16'h0001);
    check_out("shl out", 1'b1, 16'h0002, 3'b100);
    issue(OP_SHL, 16'h00FF, 16'h0004);
    check_out("shl 4", 1'b1, 16'h0FF0, 3'b000);
    issue(OP_SHL, 16'h0001, 16'h0010);
    check_out("shl 16", 1'b1, 16'h0000, 3'b110);
    issue(OP_SHR, 16'h8000, 16'h000F);
    check_out("shr 15", 1'b1, 16'h0001, 3'b000);

    // A MUL accepted at edge k is seen after edge k+15 (cycle k+16), the same
    // counting in which a single-cycle op is seen right after edge k.
    issue(OP_MUL, 16'h00FF, 16'h0101);
    check("mul accept in_ready", in_ready, 1'b0);
    check("mul accept out_valid", out_valid, 1'b0);
    wait_valid(edges, low);
    check("mul1 latency", edges, 15);
    check("mul1 in_ready low", low, 15);
    check("mul1 in_ready back", in_ready, 1'b1);
    check_out("mul1", 1'b1, 16'hFFFF, 3'b001);

    issue(OP_MUL, 16'h0100, 16'h0100);
    wait_valid(edges, low);
    check("mul2 latency", edges, 15);
    check_out("mul2", 1'b1, 16'h0000, 3'b110);

    // Reset five cycles into a multiply.
    issue(OP_MUL, 16'h00FF, 16'h0101);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid-mul rst result", result, 16'h0000);
    check("mid-mul rst flags", {OVF, Z, N}, 3'b000);
    check("mid-mul rst ctl", {out_valid, out_wr, illegal, in_ready}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("discarded mul pulses", pulses, 0);
    issue(OP_MOV, 16'h0000, 16'hA5A5);
    check_out("mov after rst", 1'b1, 16'hA5A5, 3'b001);

    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      cop      = OP_ADD;
      reg_A    = 16'(i);
      reg_B    = 16'(i);
      @(posedge clk);
      #1;
      check_out("b2b add", 1'b1, 16'(2 * i), 3'b000);
    end
    in_valid = 1'b0;

    issue(4'b1111, 16'h0001, 16'h0001);
    check("illegal out_valid", out_valid, 1'b1);
    check("illegal flag", illegal, 1'b1);
    check("illegal out_wr", out_wr, 1'b0);
    check("illegal result", result, 16'h0008);
    check("illegal flags", {OVF, Z, N}, 3'b000);
    @(posedge clk);
    #1;
    check("illegal clears", illegal, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
